mc_controller: RTL and testbench

- Multicycle MIPS control unit that sits directly upstream of the ALU.
- Sequences each instruction through a Moore FSM and drives the datapath enables and mux selects.
- Generates the 3-bit ALU operation code.
- Consumes the ALU zero flag to resolve beq.

---
 rtl/mc_pkg.sv | 43 ++++
 rtl/mc_controller_alu_decoder.sv | 36 +++
 rtl/mc_controller.sv | 181 ++++++++++++++++++
 tb/tb_mc_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// MC_JUMP_EN enables the j instruction.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// ALU operation decode from aluop and funct.
// funct_ok flags the R-type functions the ALU supports.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_ok
);

  logic [2:0] w_fn_ctl;

  always_comb begin
    w_fn_ctl = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      FN_ADD:  w_fn_ctl = ALU_ADD;
      FN_SUB:  w_fn_ctl = ALU_SUB;
      FN_AND:  w_fn_ctl = ALU_AND;
      FN_OR:   w_fn_ctl = ALU_OR;
      FN_SLT:  w_fn_ctl = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      AOP_SUB:   alucontrol = ALU_SUB;
      AOP_FUNCT: alucontrol = w_fn_ctl;
      default:   alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM driving datapath enables and selects.
// Define MC_JUMP_EN to support the j instruction.
module mc_controller
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic             pcen,
  output logic [2:0]       alucontrol,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_instret;
  logic [1:0]       w_aluop;
  logic             w_funct_ok;
  logic             w_op_ok;
  logic             w_retire;
  logic             w_irwrite;
  logic             w_pcwrite;
  logic             w_branch;
  logic             w_memwrite;
  logic             w_regwrite;
  logic             w_illegal;

  alu_decoder u_alu_decoder (
    .aluop      (w_aluop),
    .funct      (funct),
    .alucontrol (alucontrol),
    .funct_ok   (w_funct_ok)
  );

  always_comb begin
    w_op_ok = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI: w_op_ok = 1'b1;
      OP_RTYPE: w_op_ok = w_funct_ok;
`ifdef MC_JUMP_EN
      OP_J: w_op_ok = 1'b1;
`endif
      default: w_op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    unique case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        if (w_op_ok) begin
          case (op)
            OP_LW, OP_SW: w_next = S_MEMADR;
            OP_RTYPE:     w_next = S_EXECUTE;
            OP_BEQ:       w_next = S_BRANCH;
            OP_ADDI:      w_next = S_ADDIEX;
`ifdef MC_JUMP_EN
            OP_J:         w_next = S_JUMP;
`endif
            default:      w_next = S_FETCH;
          endcase
        end
      end
      S_MEMADR:  w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = S_MEMWB;
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    iord       = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    w_regwrite = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_aluop    = AOP_ADD;
    w_illegal  = 1'b0;
    w_retire   = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        alusrcb   = 2'b01;
      end
      S_DECODE: begin
        alusrcb   = 2'b11;
        w_illegal = ~w_op_ok;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        w_aluop = AOP_FUNCT;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        w_aluop  = AOP_SUB;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
        w_retire = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
        w_retire  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Strobes are squashed while reset is held so an aborted instruction cannot write.
  assign irwrite  = w_irwrite & ~reset;
  assign memwrite = w_memwrite & ~reset;
  assign regwrite = w_regwrite & ~reset;
  assign illegal  = w_illegal & ~reset;
  assign pcen     = (w_pcwrite | (w_branch & zero)) & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + CNT_W'(1);
  end

  assign instret = r_instret;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected outputs queued
// by the driver, checked by a negedge monitor. Honours MC_JUMP_EN.
module tb_mc_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    op = 6'd0;
  logic [5:0]    funct = 6'd0;
  logic          zero = 1'b0;
  logic          iord, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic          alusrca, pcen, illegal;
  logic [1:0]    alusrcb, pcsrc;
  logic [2:0]    alucontrol;
  logic [CW-1:0] instret;

  mc_controller #(.CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]   v;
    logic [CW-1:0] ir;
    string         nm;
  } exp_t;

  exp_t          q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  logic [CW-1:0] exp_ir = '0;

  function automatic logic [15:0] v(
    input logic io, mw, irw, rd, m2r, rw, asa,
    input logic [1:0] asb, pcs,
    input logic pce,
    input logic [2:0] alc,
    input logic ill
  );
    return {io, mw, irw, rd, m2r, rw, asa, asb, pcs, pce, alc, ill};
  endfunction

  logic [15:0] V_RST, V_F, V_D, V_DI, V_MA, V_MR, V_MWB, V_MWR;
  logic [15:0] V_AWB, V_AIX, V_AIW, V_J;

  function automatic logic [15:0] v_ex(input logic [2:0] alc);
    return v(0,0,0,0,0,0,1,2'b00,2'b00,0,alc,0);
  endfunction

  function automatic logic [15:0] v_br(input logic z);
    return v(0,0,0,0,0,0,1,2'b00,2'b01,z,3'b110,0);
  endfunction

  wire [15:0] w_act = {iord, memwrite, irwrite, regdst, memtoreg,
                       regwrite, alusrca, alusrcb, pcsrc, pcen,
                       alucontrol, illegal};

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      n_checks++;
      if (w_act !== e.v || instret !== e.ir) begin
        n_fail++;
        $display("FAIL %s: outputs=%b instret=%0d, expected outputs=%b instret=%0d",
                 e.nm, w_act, instret, e.v, e.ir);
      end
    end
  end

  task automatic cyc(input logic [15:0] e, input string nm);
    q.push_back('{v: e, ir: exp_ir, nm: nm});
    @(posedge clk);
    #1;
  endtask

  task automatic retire();
    exp_ir = exp_ir + 1'b1;
  endtask

  task automatic i_lw();
    op = 6'b100011; funct = 6'd0;
    cyc(V_F, "lw_fetch"); cyc(V_D, "lw_decode");
    cyc(V_MA, "lw_memadr"); cyc(V_MR, "lw_memrd");
    cyc(V_MWB, "lw_memwb"); retire();
  endtask

  task automatic i_r(input logic [5:0] f, input logic [2:0] alc, input string nm);
    op = 6'b000000; funct = f;
    cyc(V_F, {nm, "_fetch"}); cyc(V_D, {nm, "_decode"});
    cyc(v_ex(alc), {nm, "_execute"}); cyc(V_AWB, {nm, "_aluwb"});
    retire();
  endtask

  task automatic i_rill(input logic [5:0] f);
    op = 6'b000000; funct = f;
    cyc(V_F, "rill_fetch"); cyc(V_DI, "rill_decode");
  endtask

  task automatic i_beq(input logic z, input string nm);
    op = 6'b000100; funct = 6'd0; zero = z;
    cyc(V_F, {nm, "_fetch"}); cyc(V_D, {nm, "_decode"});
    cyc(v_br(z), {nm, "_branch"}); retire();
  endtask

  task automatic i_addi(input string nm);
    op = 6'b001000; funct = 6'd0;
    cyc(V_F, {nm, "_fetch"}); cyc(V_D, {nm, "_decode"});
    cyc(V_AIX, {nm, "_addiex"}); cyc(V_AIW, {nm, "_addiwb"});
    retire();
  endtask

  task automatic i_sw();
    op = 6'b101011; funct = 6'd0; zero = 1'b1;
    cyc(V_F, "sw_fetch"); cyc(V_D, "sw_decode");
    cyc(V_MA, "sw_memadr"); cyc(V_MWR, "sw_memwr"); retire();
    zero = 1'b0;
  endtask

  task automatic i_j();
    op = 6'b000010; funct = 6'd0;
    cyc(V_F, "j_fetch");
`ifdef MC_JUMP_EN
    cyc(V_D, "j_decode"); cyc(V_J, "j_jump"); retire();
`else
    cyc(V_DI, "j_illegal");
`endif
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    V_RST = v(0,0,0,0,0,0,0,2'b01,2'b00,0,3'b010,0);
    V_F   = v(0,0,1,0,0,0,0,2'b01,2'b00,1,3'b010,0);
    V_D   = v(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,0);
    V_DI  = v(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,1);
    V_MA  = v(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0);
    V_MR  = v(1,0,0,0,0,0,0,2'b00,2'b00,0,3'b010,0);
    V_MWB = v(0,0,0,0,1,1,0,2'b00,2'b00,0,3'b010,0);
    V_MWR = v(1,1,0,0,0,0,0,2'b00,2'b00,0,3'b010,0);
    V_AWB = v(0,0,0,1,0,1,0,2'b00,2'b00,0,3'b010,0);
    V_AIX = v(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0);
    V_AIW = v(0,0,0,0,0,1,0,2'b00,2'b00,0,3'b010,0);
    V_J   = v(0,0,0,0,0,0,0,2'b00,2'b10,1,3'b010,0);

    @(posedge clk); #1;
    cyc(V_RST, "reset_hold0");
    cyc(V_RST, "reset_hold1");
    reset = 1'b0;

    i_lw();
    i_r(6'b101010, 3'b111, "slt");
    i_r(6'b100010, 3'b110, "sub");
    i_r(6'b100101, 3'b001, "or");
    i_rill(6'b000111);
    i_beq(1'b1, "beq_taken");
    i_beq(1'b0, "beq_nottaken");
    i_addi("addi");
    i_sw();
    i_j();

    op = 6'b100011; funct = 6'd0;
    cyc(V_F, "abort_fetch"); cyc(V_D, "abort_decode");
    cyc(V_MA, "abort_memadr");
    #1 reset = 1'b1;
    exp_ir = '0;
    cyc(V_RST, "reset_async_memrd");
    cyc(V_RST, "reset_hold2");
    reset = 1'b0;

    for (int i = 0; i < 16; i++) i_addi("wrap");
    op = 6'd0; funct = 6'b100000;
    cyc(V_F, "wrap_zero_fetch");

    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
